// File: rtl/cmp_arbiter.sv
// Round-robin front end that shares one WIDTH-bit comparator between NREQ requesters.
// Optional macro CMP_ARB_ILLEGAL_OP_EN: ops 110/111 answer rsp_err=1, rsp_result=0.
module cmp_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  input  logic [NREQ*3-1:0]         req_op,
  output logic [WIDTH-1:0]          cmp_a,
  output logic [WIDTH-1:0]          cmp_b,
  output logic [2:0]                cmp_op,
  input  logic                      cmp_out,
  output logic [NREQ-1:0]           rsp_valid,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic                      rsp_result,
  output logic                      rsp_err
);

  localparam int ID_W = $clog2(NREQ);

  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [WIDTH-1:0] cmp_a_q, cmp_a_d;
  logic [WIDTH-1:0] cmp_b_q, cmp_b_d;
  logic [2:0]       cmp_op_q, cmp_op_d;
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_result_q, rsp_result_d;

  logic             gnt_any;
  logic [ID_W-1:0]  gnt_id;
  logic             accept;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       sel_op;
  logic             eval_result;

  // Rotating priority search: first valid requester at or after rr_ptr.
  always_comb begin
    logic [ID_W-1:0] cand;
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NREQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  assign sel_a  = req_a[int'(gnt_id)*WIDTH +: WIDTH];
  assign sel_b  = req_b[int'(gnt_id)*WIDTH +: WIDTH];
  assign sel_op = req_op[int'(gnt_id)*3 +: 3];

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_any) state_d = EVAL;
      EVAL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: grant only while idle
  always_comb begin
    req_ready = '0;
    accept    = 1'b0;
    if (state_q == IDLE && gnt_any) begin
      req_ready[gnt_id] = 1'b1;
      accept            = 1'b1;
    end
  end

`ifdef CMP_ARB_ILLEGAL_OP_EN
  logic ill_q, ill_d;
  logic rsp_err_q, rsp_err_d;
  logic sel_ill;

  assign sel_ill = (sel_op[2:1] == 2'b11);

  always_comb begin
    ill_d     = ill_q;
    rsp_err_d = rsp_err_q;
    if (accept) ill_d = sel_ill;
    if (state_q == EVAL) rsp_err_d = ill_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ill_q     <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      ill_q     <= ill_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  // Illegal ops still occupy the comparator slot, but with a neutral op.
  assign eval_result = ill_q ? 1'b0 : cmp_out;
  assign rsp_err     = rsp_err_q;
`else
  assign eval_result = cmp_out;
  assign rsp_err     = 1'b0;
`endif

  // Accept stage: latch the winner's operands, advance the pointer past it.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    cmp_a_d  = cmp_a_q;
    cmp_b_d  = cmp_b_q;
    cmp_op_d = cmp_op_q;
    if (accept) begin
      rr_ptr_d = (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + ID_W'(1);
      id_d     = gnt_id;
      cmp_a_d  = sel_a;
      cmp_b_d  = sel_b;
`ifdef CMP_ARB_ILLEGAL_OP_EN
      cmp_op_d = sel_ill ? 3'b000 : sel_op;
`else
      cmp_op_d = sel_op;
`endif
    end
  end

  // Response stage: one-cycle pulse to the owner; id/result hold afterwards.
  always_comb begin
    rsp_valid_d  = '0;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    if (state_q == EVAL) begin
      rsp_valid_d[id_q] = 1'b1;
      rsp_id_d          = id_q;
      rsp_result_d      = eval_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      id_q         <= '0;
      cmp_a_q      <= '0;
      cmp_b_q      <= '0;
      cmp_op_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      id_q         <= id_d;
      cmp_a_q      <= cmp_a_d;
      cmp_b_q      <= cmp_b_d;
      cmp_op_q     <= cmp_op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign cmp_a      = cmp_a_q;
  assign cmp_b      = cmp_b_q;
  assign cmp_op     = cmp_op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

endmodule
